// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// key-code map and small row/column helper functions.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  // Indexed [row][col]; row 3 carries E,0,F,D as on the physical pad
  localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Clearable, enable-gated up-counter; done flags the last counting cycle so
// the owner can act on the edge that completes MAX counted cycles.
module cycle_timer #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] LAST = W'(MAX - 1);
  localparam logic [W-1:0] TOP  = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and saturate at MAX
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != TOP)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan_controller.sv
// 4x4 keypad scanner: walks an active-low column strobe, debounces press and
// release on one locked row, and reports one registered key code per press.
module keypad_scan_controller
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] rows_sync,
  output logic [NUM_COLS-1:0] cols,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  state_e              state_q, state_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [1:0]          row_idx_q, row_idx_d;
  logic [NUM_COLS-1:0] cols_q, cols_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;

  logic settle_clr_s, settle_en_s, settle_done_s;
  logic deb_clr_s, deb_en_s, deb_done_s;
  logic row_low_s;

  cycle_timer #(.MAX(SETTLE_CYCLES)) u_settle (
    .clk    (clk),
    .reset  (reset),
    .clear  (settle_clr_s),
    .enable (settle_en_s),
    .done   (settle_done_s)
  );

  cycle_timer #(.MAX(DEBOUNCE_CYCLES)) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .clear  (deb_clr_s),
    .enable (deb_en_s),
    .done   (deb_done_s)
  );

  assign row_low_s = ~rows_sync[row_idx_q];

  // Next-state and timer control; timers are held clear unless a state counts
  always_comb begin
    state_d      = state_q;
    col_idx_d    = col_idx_q;
    row_idx_d    = row_idx_q;
    key_code_d   = key_code_q;
    key_valid_d  = 1'b0;
    key_held_d   = key_held_q;
    settle_en_s  = 1'b0;
    settle_clr_s = 1'b1;
    deb_en_s     = 1'b0;
    deb_clr_s    = 1'b1;

    case (state_q)
      SCAN: begin
        settle_en_s  = 1'b1;
        settle_clr_s = settle_done_s;
        if (settle_done_s) begin
          if (rows_sync == 4'b1111) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = lowest_low_row(rows_sync);
            state_d   = PRESS_DB;
          end
        end else begin
          state_d = SCAN;
        end
      end

      PRESS_DB: begin
        if (row_low_s) begin
          deb_en_s  = 1'b1;
          deb_clr_s = deb_done_s;
          if (deb_done_s) begin
            key_code_d  = KEY_MAP[row_idx_q][col_idx_q];
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            state_d     = HELD;
          end else begin
            state_d = PRESS_DB;
          end
        end else begin
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end
      end

      // Lockout: only the locked row in the locked column is watched
      HELD: begin
        if (row_low_s) begin
          state_d = HELD;
        end else begin
          state_d = RELEASE_DB;
        end
      end

      RELEASE_DB: begin
        if (!row_low_s) begin
          deb_en_s  = 1'b1;
          deb_clr_s = deb_done_s;
          if (deb_done_s) begin
            key_held_d = 1'b0;
            col_idx_d  = col_idx_q + 2'd1;
            state_d    = SCAN;
          end else begin
            state_d = RELEASE_DB;
          end
        end else begin
          state_d = RELEASE_DB;
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase

    cols_d = col_drive(col_idx_d);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      cols_q      <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      cols_q      <= cols_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign cols      = cols_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: doc/keypad_scan_controller.md
Name: keypad_scan_controller

Overview:
- Scans a 4x4 matrix keypad by driving one column low at a time.
- Reads the row lines through the team's two-flop synchronizer, debounces press and release, and emits one registered key code per press.
- Sits between the keypad pins (with the synchronizer on the row inputs) and the display/key-history logic.
- Enforces single-key lockout: no new key is reported until the held key is fully released.

Parameters:
- SETTLE_CYCLES, 4, cycles the block waits after changing the column before sampling rows. Must be ≥3 to cover 2 synchronizer stages plus pad settling.
- DEBOUNCE_CYCLES, 50000, cycles of continuous stable level required to accept a press or a release. Must be ≥1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rows_sync  input  4  synchronized row lines, active-low (0 = key in that row conducting).
- cols  output  4  column drive, active-low one-hot (exactly one bit 0 at all times).
- key_code  output  4  hex code of the last accepted key; holds its value between presses.
- key_valid  output  1  one-cycle pulse, asserted in the same cycle key_code updates.
- key_held  output  1  high from press acceptance until release is accepted.

Behaviour:
- Reset (async, active-high): state=SCAN, col_idx=0, cols=4'b1110, key_code=0, key_valid=0, key_held=0, all counters=0.
- All outputs are registered.
- SCAN:
  - Drive column col_idx and count SETTLE_CYCLES.
  - At count end, sample rows_sync.
  - If all rows are 1: col_idx advances, wrapping 3→0; cols updates; counter clears.
  - Otherwise: lock row_idx to the lowest-index 0 bit, keep the column, go to PRESS_DB.
- PRESS_DB:
  - Increment the counter each cycle that rows_sync[row_idx]==0.
  - If that row reads 1 before DEBOUNCE_CYCLES is reached: abandon, advance to the next column, return to SCAN.
  - At DEBOUNCE_CYCLES: key_code←map(row_idx,col_idx), key_valid=1 for exactly 1 cycle, key_held←1, go to HELD.
- HELD:
  - Column stays driven.
  - Other rows and columns are ignored (lockout).
  - When rows_sync[row_idx]==1: clear the counter, go to RELEASE_DB.
- RELEASE_DB:
  - Count cycles with rows_sync[row_idx]==1.
  - Any 0 (bounce) clears the counter and the block stays in RELEASE_DB.
  - At DEBOUNCE_CYCLES: key_held←0, advance to the next column, go to SCAN.
  - key_valid is never asserted here, so a bounce cannot produce a second key.
- Key map (row,col):
  - r0 = 1,2,3,A
  - r1 = 4,5,6,B
  - r2 = 7,8,9,C
  - r3 = E,0,F,D
- Simultaneous keys in the same column: lowest row wins. Keys in other columns are not seen until the scan reaches them.
- Counter width is $clog2(max(SETTLE_CYCLES,DEBOUNCE_CYCLES)+1). The counter saturates and never wraps.
- Reset mid-debounce or mid-hold returns to the reset state immediately. No key_valid is produced.

Decomposition:
- Package keypad_pkg holds:
  - state enum {SCAN, PRESS_DB, HELD, RELEASE_DB};
  - 4x4 key-map constant array;
  - NUM_ROWS=4 and NUM_COLS=4.
- One sub-module, cycle_timer, is used twice (settle and debounce):
  - inputs clear, enable;
  - output done at terminal count;
  - parameter MAX.

Test Plan (SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8 in simulation):
- Idle, rows=4'b1111 → cols cycles 1110→1101→1011→0111→1110, one step every 4 cycles after reset; key_valid stays 0.
- Press row1 while cols=1101, held 20 cycles → one key_valid pulse with key_code=5, 8 cycles after detection; key_held=1; cols frozen at 1101.
- Press row2/col0 with a 3-cycle glitch, then release → no key_valid; scan resumes at col1.
- Hold key 9, release with 2 bounces of 3 cycles each → key_held drops only after 8 clean cycles; exactly one key_valid total.
- While holding 1 (r0c0), also press D (r3c3) → no second key_valid. After releasing 1 with D still held, the next scan of col3 reports key_code=D.
- Assert reset during HELD with key_code=A → cols=1110, key_held=0, key_code=0 asynchronously, before the next clk edge.
